// File: rtl/pwm_interlock_pkg.sv
// Shared definitions for the PWM gate interlock.
//   leg_state_t        per-leg interlock FSM state
//   N_PAIRS_DEFAULT    default number of complementary legs
//   SAFE_STATE_DEFAULT default gate drive for reset / disabled / faulted
//   leg_a_index()      bit position of a leg's A line in the pwm/gate vectors
package pwm_interlock_pkg;

    typedef enum logic [2:0] {
        OFF,
        A_ON,
        B_ON,
        DEAD_A,
        DEAD_B
    } leg_state_t;

    localparam int unsigned N_PAIRS_DEFAULT = 6;

    localparam logic [2*N_PAIRS_DEFAULT-1:0] SAFE_STATE_DEFAULT = '0;

    // Pins are grouped in banks of three legs: A lines first, then the
    // matching B lines three positions higher.
    function automatic int unsigned leg_a_index(input int unsigned leg);
        return (leg / 3) * 6 + (leg % 3);
    endfunction

endpackage

// File: rtl/interlock_leg.sv
// One complementary leg: request decode, break-before-make FSM and the
// deadtime counter.
//   clock, reset    system clock, synchronous active-low reset
//   force_off       drive the leg to OFF on the next edge (disable / fault)
//   pwm_a, pwm_b    raw PWM request lines for this leg
//   deadtime        deadtime in cycles, loaded when entering a DEAD state
//   gate_a_next     A gate value for the coming edge (registered by the top)
//   gate_b_next     B gate value for the coming edge (registered by the top)
//   both_req        A and B requested together this cycle
module interlock_leg
    import pwm_interlock_pkg::*;
#(
    parameter int unsigned DT_WIDTH = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                force_off,
    input  logic                pwm_a,
    input  logic                pwm_b,
    input  logic [DT_WIDTH-1:0] deadtime,
    output logic                gate_a_next,
    output logic                gate_b_next,
    output logic                both_req
);

    leg_state_t          state;
    leg_state_t          state_next;
    logic [DT_WIDTH-1:0] cnt;
    logic [DT_WIDTH-1:0] cnt_next;
    logic                req_a;
    logic                req_b;

    // Both lines high is treated as no request at all.
    assign req_a    = pwm_a & ~pwm_b;
    assign req_b    = pwm_b & ~pwm_a;
    assign both_req = pwm_a & pwm_b;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (force_off) begin
            state_next = OFF;
            cnt_next   = '0;
        end else begin
            unique case (state)
                OFF: begin
                    if (req_a) begin
                        state_next = DEAD_A;
                        cnt_next   = deadtime;
                    end else if (req_b) begin
                        state_next = DEAD_B;
                        cnt_next   = deadtime;
                    end
                end
                A_ON: begin
                    if (!req_a) begin
                        if (req_b) begin
                            state_next = DEAD_B;
                            cnt_next   = deadtime;
                        end else begin
                            state_next = OFF;
                            cnt_next   = '0;
                        end
                    end
                end
                B_ON: begin
                    if (!req_b) begin
                        if (req_a) begin
                            state_next = DEAD_A;
                            cnt_next   = deadtime;
                        end else begin
                            state_next = OFF;
                            cnt_next   = '0;
                        end
                    end
                end
                DEAD_A: begin
                    if (req_b) begin
                        state_next = DEAD_B;
                        cnt_next   = deadtime;
                    end else if (!req_a) begin
                        state_next = OFF;
                        cnt_next   = '0;
                    end else if (cnt == '0) begin
                        state_next = A_ON;
                    end else begin
                        cnt_next = cnt - DT_WIDTH'(1);
                    end
                end
                DEAD_B: begin
                    if (req_a) begin
                        state_next = DEAD_A;
                        cnt_next   = deadtime;
                    end else if (!req_b) begin
                        state_next = OFF;
                        cnt_next   = '0;
                    end else if (cnt == '0) begin
                        state_next = B_ON;
                    end else begin
                        cnt_next = cnt - DT_WIDTH'(1);
                    end
                end
                default: begin
                    state_next = OFF;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // The count only decrements while non-zero (reaching zero leaves DEAD),
    // so it saturates at 0 and never wraps.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= OFF;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Decoded from the next state so the top-level output register lands
    // in the same edge as the state change: a falling request clears the
    // gate one edge after it is sampled.
    assign gate_a_next = (state_next == A_ON);
    assign gate_b_next = (state_next == B_ON);

endmodule

// File: rtl/pwm_gate_interlock.sv
// Gate-driver interlock between the PWM generator and the gate pins.
// Enforces break-before-make deadtime on each complementary leg, blocks
// shoot-through requests and latches faults into a safe all-off state.
//   clock          system clock
//   reset          synchronous, active-low
//   pwm_in         raw PWM, leg i: A = bit (i/3)*6+i%3, B = A+3
//   enable         0 forces SAFE_STATE and returns every leg to OFF
//   deadtime       deadtime in cycles, sampled when a leg enters DEAD
//   fault          external fault, asynchronous level
//   fault_clear    single-cycle pulse, clears the latch when fault is low
//   gate_out       registered gate drive, same layout as pwm_in
//   fault_latched  sticky fault status
//   shoot_through  sticky per-leg flag for A and B requested together
// N_PAIRS is expected to be a multiple of 3 to match the bank pin layout.
module pwm_gate_interlock
    import pwm_interlock_pkg::*;
#(
    parameter int unsigned           N_PAIRS    = N_PAIRS_DEFAULT,
    parameter int unsigned           DT_WIDTH   = 8,
    parameter logic [2*N_PAIRS-1:0]  SAFE_STATE = (2*N_PAIRS)'(SAFE_STATE_DEFAULT)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [2*N_PAIRS-1:0] pwm_in,
    input  logic                 enable,
    input  logic [DT_WIDTH-1:0]  deadtime,
    input  logic                 fault,
    input  logic                 fault_clear,
    output logic [2*N_PAIRS-1:0] gate_out,
    output logic                 fault_latched,
    output logic [N_PAIRS-1:0]   shoot_through
);

    logic                 fault_meta;
    logic                 fault_s;
    logic                 clear_ok;
    logic                 fault_next;
    logic                 force_off;
    logic [N_PAIRS-1:0]   both_req;
    logic [N_PAIRS-1:0]   shoot_next;
    logic [2*N_PAIRS-1:0] gate_next;

    // Two-stage synchronizer for the asynchronous fault input.
    always_ff @(posedge clock) begin
        if (!reset) begin
            fault_meta <= 1'b0;
            fault_s    <= 1'b0;
        end else begin
            fault_meta <= fault;
            fault_s    <= fault_meta;
        end
    end

    // The legs are forced off from the next latch value, so gate_out goes
    // safe on the same edge fault_latched rises. A synchronized fault beats
    // a simultaneous clear.
    always_comb begin
        clear_ok   = fault_clear & ~fault_s;
        fault_next = fault_s | (fault_latched & ~clear_ok);
        force_off  = ~enable | fault_next;
        shoot_next = (clear_ok ? '0 : shoot_through) | both_req;
    end

    for (genvar i = 0; i < N_PAIRS; i++) begin : g_leg
        localparam int unsigned IA = leg_a_index(i);
        localparam int unsigned IB = IA + 3;

        interlock_leg #(
            .DT_WIDTH (DT_WIDTH)
        ) u_leg (
            .clock       (clock),
            .reset       (reset),
            .force_off   (force_off),
            .pwm_a       (pwm_in[IA]),
            .pwm_b       (pwm_in[IB]),
            .deadtime    (deadtime),
            .gate_a_next (gate_next[IA]),
            .gate_b_next (gate_next[IB]),
            .both_req    (both_req[i])
        );
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            gate_out      <= SAFE_STATE;
            fault_latched <= 1'b0;
            shoot_through <= '0;
        end else begin
            gate_out      <= force_off ? SAFE_STATE : gate_next;
            fault_latched <= fault_next;
            shoot_through <= shoot_next;
        end
    end

endmodule
